ring_freq_meter: RTL and testbench
==================================

Name: ring_freq_meter

Overview:
Measures the frequency of a free-running ring-oscillator output by counting its rising edges over a fixed window of system-clock cycles. It is the reading end of the ring-oscillator path: the oscillator produces an asynchronous square wave, and this block synchronises it into clk, gates a counting window, and presents a latched edge count. It supports single-shot and continuous measurement, with a one-cycle result_valid pulse per completed window.

Parameters:
WINDOW_CYCLES, 1024, measurement window length in clk cycles (>=2)
CNT_W, 16, width of the edge counter and result
SYNC_STAGES, 2, flip-flops in the osc_in synchroniser chain (>=2)

Ports:
clk  input  1  system clock; the block has one clock
rst  input  1  synchronous, active-high reset
osc_in  input  1  asynchronous ring-oscillator output
start  input  1  level-sampled request to begin a measurement
cont  input  1  when high at window end, the next window re-arms automatically
busy  output  1  high in ARM and MEASURE
result  output  CNT_W  edge count of the last completed window
result_valid  output  1  one-cycle pulse when result updates
overflow  output  1  last completed window saturated the counter

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; busy=0, result=0, result_valid=0, overflow=0; synchroniser, edge register, edge counter and window counter cleared.
- Synchroniser: osc_in passes through SYNC_STAGES flops. The edge register holds the previous synchronised sample. A rising edge is sync_out=1 and prev=0. The synchroniser runs in every state. Only edges detected during MEASURE are counted.
- Accuracy: accurate only for osc_in period > 2 clk periods. Faster inputs alias. No detection of this case is required.
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE: if start=1, next state is ARM; otherwise stay in IDLE.
- ARM: lasts 1 cycle. Clears the edge counter and the overflow accumulator, and loads the window counter with WINDOW_CYCLES-1. Next state is MEASURE.
- MEASURE: lasts exactly WINDOW_CYCLES cycles.
  - Each cycle with a detected edge increments the edge counter.
  - The edge counter saturates at 2^CNT_W-1. A detected edge while saturated sets the overflow accumulator.
  - The window counter decrements each cycle. When it is 0 in MEASURE, next state is DONE.
- DONE: lasts 1 cycle. result<=edge counter, overflow<=accumulator, result_valid=1 for this cycle only. Next state is ARM if cont=1 or start=1, else IDLE.
- Timing: start high at edge T gives ARM at T+1, MEASURE from T+2 to T+1+WINDOW_CYCLES, DONE at T+2+WINDOW_CYCLES.
- busy: high in ARM and MEASURE; low in IDLE and DONE.
- Continuous mode: window period is WINDOW_CYCLES+2 cycles.
- result and overflow hold their value until the next DONE; they are never cleared except by rst.
- start is ignored in ARM and MEASURE. Holding start high gives back-to-back windows, same as cont.
- rst mid-MEASURE: immediate return to IDLE with all outputs cleared. No result_valid is produced for the aborted window.
- Widths: window counter width is clog2(WINDOW_CYCLES). All arithmetic is unsigned with no wrap.

Test Plan:
- Reset state: rst high 3 cycles then low, osc_in toggling -> busy=0, result=0, result_valid=0, overflow=0, no activity without start.
- Single shot (WINDOW_CYCLES=16, osc period 4 clk): start high 1 cycle at T -> busy high T+1..T+17; result_valid one cycle at T+18; result=4 (±1 for phase); busy=0 at T+18.
- Static input (osc_in held 1, then held 0): start -> result=0 for both, overflow=0.
- Saturation (CNT_W=2, WINDOW_CYCLES=32, osc period 4) -> result=3, overflow=1. A following window with osc_in static -> result=0, overflow=0.
- Continuous mode (cont=1, WINDOW_CYCLES=16) -> result_valid pulses every 18 cycles. Drop cont -> the window in progress completes, then IDLE.
- Abort (rst asserted at cycle 8 of MEASURE) -> IDLE next cycle, no result_valid, result=0. A subsequent start measures normally.

Source files
------------

// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter.
// Synchronises an asynchronous oscillator into clk, counts its rising edges
// over a fixed window of clk cycles and latches the count as the result.
// Single-shot (start) and continuous (cont) measurement are supported.
module ring_freq_meter #(
   parameter int WINDOW_CYCLES = 1024,
   parameter int CNT_W         = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             osc_in,
   input  logic             start,
   input  logic             cont,
   output logic             busy,
   output logic [CNT_W-1:0] result,
   output logic             result_valid,
   output logic             overflow
);

   localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   rise;

   logic [CNT_W-1:0] edge_cnt;
   logic             ovf_acc;
   logic [WIN_W-1:0] win_cnt;

   logic             cnt_inc;
   logic             ovf_hit;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;
   logic             win_end;

   // Synchroniser chain plus previous-sample register; runs in every state
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], osc_in};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~prev;

   // Saturating edge count and overflow accumulation for the current cycle
   always_comb begin
      cnt_inc  = (state == MEASURE) && rise && (edge_cnt != CNT_MAX);
      ovf_hit  = (state == MEASURE) && rise && (edge_cnt == CNT_MAX);
      cnt_next = edge_cnt + CNT_W'(cnt_inc);
      ovf_next = ovf_acc | ovf_hit;
      win_end  = (state == MEASURE) && (win_cnt == '0);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // FSM next-state logic; start is only looked at in IDLE and DONE
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = ARM;
         ARM:     next_state = MEASURE;
         MEASURE: if (win_end) next_state = DONE;
         DONE:    next_state = (cont || start) ? ARM : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      busy         = (state == ARM) || (state == MEASURE);
      result_valid = (state == DONE);
   end

   // Window datapath. The result is captured on the edge that enters DONE
   // (including the last MEASURE cycle's edge) so that result and overflow
   // already carry the new window's value while result_valid is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt <= '0;
         ovf_acc  <= 1'b0;
         win_cnt  <= '0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            ARM: begin
               edge_cnt <= '0;
               ovf_acc  <= 1'b0;
               win_cnt  <= WIN_LOAD;
            end
            MEASURE: begin
               edge_cnt <= cnt_next;
               ovf_acc  <= ovf_next;
               if (win_end) begin
                  result   <= cnt_next;
                  overflow <= ovf_next;
               end else begin
                  win_cnt <= win_cnt - WIN_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: logs the oscillator as sampled on every clk edge
// and predicts each window's edge count from that log with plain arithmetic.
module tb_ring_freq_meter;

   localparam int W    = 16;
   localparam int CW   = 3;
   localparam int S    = 3;
   localparam int MAXC = (1 << CW) - 1;
   localparam int LOGN = 16384;

   logic          clk = 1'b0;
   logic          rst, osc_in, start, cont;
   logic          busy, result_valid, overflow;
   logic [CW-1:0] result;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit osc_log [0:LOGN-1];
   int osc_half   = 0;
   bit osc_static = 1'b0;

   ring_freq_meter #(.WINDOW_CYCLES(W), .CNT_W(CW), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .cont(cont),
      .busy(busy), .result(result), .result_valid(result_valid), .overflow(overflow)
   );

   // posedges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // oscillator changes only at 2 + 10k ns, never on a clk edge
   initial begin
      osc_in = 1'b0;
      #2;
      forever begin
         if (osc_half == 0) begin
            osc_in = osc_static;
            #10;
         end else begin
            #(10 * osc_half) osc_in = ~osc_in;
         end
      end
   end

   // record the value the DUT samples at each clk edge
   always @(posedge clk) begin
      if (cyc < LOGN) osc_log[cyc] = osc_in;
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // rising edges seen through an S-deep synchroniser during the W cycles
   // after the ARM cycle that follows start edge e0
   function automatic int model_edges(input int e0);
      int c = 0;
      for (int n = e0 + 1; n <= e0 + W; n++)
         if (osc_log[n-S+1] && !osc_log[n-S]) c++;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start for one edge; returns the index of the edge that sampled it
   task automatic start_pulse(output int e0);
      @(negedge clk);
      start = 1'b1;
      tick();
      e0 = cyc - 1;
      start = 1'b0;
   endtask

   // called 1 ns after edge e0 (state ARM); runs to the DONE cycle
   task automatic check_window(input string tag, input int e0);
      int  edges;
      bit  shape_ok;
      shape_ok = (busy === 1'b1) && (result_valid === 1'b0);
      for (int k = 1; k <= W; k++) begin
         tick();
         if (busy !== 1'b1 || result_valid !== 1'b0) shape_ok = 1'b0;
      end
      tick();
      edges = model_edges(e0);
      check({tag, "_busy_shape"}, shape_ok, 1);
      check({tag, "_valid"}, result_valid, 1);
      check({tag, "_busy_done"}, busy, 0);
      check({tag, "_result"}, result, (edges > MAXC) ? MAXC : edges);
      check({tag, "_ovf"}, overflow, (edges > MAXC) ? 1 : 0);
   endtask

   initial begin
      int  e0;
      bit  quiet;
      rst = 1'b1; start = 1'b0; cont = 1'b0;
      osc_half = 2;

      // reset with the oscillator running
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_valid", result_valid, 0);
      check("rst_ovf", overflow, 0);
      @(negedge clk) rst = 1'b0;
      quiet = 1'b1;
      repeat (20) begin
         tick();
         if (busy !== 1'b0 || result_valid !== 1'b0 || result !== '0) quiet = 1'b0;
      end
      check("idle_quiet", quiet, 1);

      // single shot, period 4 clk: 4 edges give or take one for phase
      start_pulse(e0);
      check_window("single", e0);
      check("single_near4", (result >= 3 && result <= 5), 1);
      tick();
      check("single_valid_drop", result_valid, 0);
      check("single_idle", busy, 0);

      // static high, then static low
      osc_half = 0; osc_static = 1'b1;
      repeat (6) tick();
      start_pulse(e0);
      check_window("static1", e0);
      check("static1_zero", result, 0);
      osc_static = 1'b0;
      repeat (6) tick();
      start_pulse(e0);
      check_window("static0", e0);
      check("static0_zero", result, 0);

      // saturation: an edge every 2 cycles gives 8 edges in 16 cycles
      osc_half = 1;
      repeat (6) tick();
      start_pulse(e0);
      check_window("sat", e0);
      check("sat_max", result, MAXC);
      check("sat_ovf1", overflow, 1);
      osc_half = 0; osc_static = 1'b0;
      repeat (6) tick();
      start_pulse(e0);
      check_window("after_sat", e0);
      check("after_sat_ovf0", overflow, 0);

      // continuous: windows every W+2 cycles, drop cont in the third
      osc_half = 3;
      cont = 1'b1;
      start_pulse(e0);
      check_window("cont0", e0);
      for (int w = 1; w < 3; w++) begin
         tick();
         e0 = cyc - 1;
         if (w == 2) cont = 1'b0;
         check_window($sformatf("cont%0d", w), e0);
      end
      quiet = 1'b1;
      repeat (W + 4) begin
         tick();
         if (busy !== 1'b0 || result_valid !== 1'b0) quiet = 1'b0;
      end
      check("cont_stop_idle", quiet, 1);

      // abort at MEASURE cycle 8, then a normal measurement
      osc_half = 2;
      start_pulse(e0);
      repeat (8) tick();
      check("abort_busy_pre", busy, 1);
      @(negedge clk) rst = 1'b1;
      tick();
      check("abort_busy", busy, 0);
      check("abort_result", result, 0);
      check("abort_ovf", overflow, 0);
      @(negedge clk) rst = 1'b0;
      quiet = 1'b1;
      repeat (30) begin
         tick();
         if (result_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      check("abort_no_valid", quiet, 1);
      start_pulse(e0);
      check_window("post_abort", e0);

      // randomized single shots and continuous bursts
      for (int r = 0; r < 8; r++) begin
         osc_half   = $urandom_range(0, 6);
         osc_static = 1'($urandom_range(0, 1));
         repeat ($urandom_range(S + 2, 12)) tick();
         cont = 1'($urandom_range(0, 1));
         start_pulse(e0);
         check_window($sformatf("rnd%0d", r), e0);
         if (cont) begin
            tick();
            e0 = cyc - 1;
            cont = 1'b0;
            check_window($sformatf("rnd%0d_b", r), e0);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
